// File: rtl/div_share_pkg.sv
// Shared types and constants for the divider-sharing controller.
// Contents: FSM state encoding, the stall limit used to detect a divider
// that never drops div_ready, and a helper that builds an all-ones value.
package div_share_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    CAPTURE   = 3'd4
  } state_e;

  // Cycles of div_ready=1 seen in WAIT_BUSY before the divide is taken as done.
  localparam int STALL_LIMIT = 2;

  // All-ones value of the given width (up to 32 bits), used as the
  // divide-by-zero quotient.
  function automatic logic [31:0] all_ones(input int unsigned width);
    if (width >= 32) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req      - request vector
//   ptr      - highest-priority index; search runs ptr, ptr+1, ... mod N_REQ
//   gnt      - one-hot grant
//   gnt_idx  - binary index of the grant
//   gnt_vld  - any request present
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin controller sharing one iterative divider among N_REQ requesters.
// Optional build macro: DIV_ZERO_BYPASS_EN (zero divisor skips the divider,
// returns all-ones quotient / dividend remainder and pulses div0_err).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req                   - per-requester request level, held until done
//   dvnd_flat, dvsr_flat  - packed operands, requester i at [i*W +: W]
//   busy, grant_idx       - FSM not idle / requester being served
//   done, quo_out, rem_out- one-hot completion pulse and registered result
//   div_start, div_dvnd, div_dvsr - divider launch interface
//   div_ready, div_quo, div_rem   - divider status and result
//   div0_err              - (DIV_ZERO_BYPASS_EN only) zero-divisor flag with done
//
// state     | meaning
// IDLE      | arbitrate; no grant in the cycle done is asserted
// LOAD      | operands latched; wait for div_ready, then fire div_start
// WAIT_BUSY | wait for divider to drop div_ready (or stall limit -> done)
// WAIT_DONE | wait for div_ready to return
// CAPTURE   | register result, pulse done, advance pointer
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] dvnd_flat,
  input  logic [N_REQ*W-1:0] dvsr_flat,
  output logic               busy,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [N_REQ-1:0]   done,
  output logic [W-1:0]       quo_out,
  output logic [W-1:0]       rem_out,
  output logic               div_start,
  output logic [W-1:0]       div_dvnd,
  output logic [W-1:0]       div_dvsr,
  input  logic               div_ready,
  input  logic [W-1:0]       div_quo,
  input  logic [W-1:0]       div_rem
`ifdef DIV_ZERO_BYPASS_EN
  ,
  output logic               div0_err
`endif
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [N_REQ-1:0]   grant_oh_q, grant_oh_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [W-1:0]       dvnd_q, dvnd_d;
  logic [W-1:0]       dvsr_q, dvsr_d;
  logic [W-1:0]       quo_q, quo_d;
  logic [W-1:0]       rem_q, rem_d;
  logic               start_q, start_d;
  logic [1:0]         stall_q, stall_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;

`ifdef DIV_ZERO_BYPASS_EN
  logic               div0_q, div0_d;
  logic [31:0]        ones32;
  assign ones32 = all_ones(W);
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    grant_oh_d  = grant_oh_q;
    done_d      = '0;
    dvnd_d      = dvnd_q;
    dvsr_d      = dvsr_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    start_d     = 1'b0;
    stall_d     = stall_q;
`ifdef DIV_ZERO_BYPASS_EN
    div0_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // Requester still holds req during its done cycle, so skip that cycle.
        if (arb_vld && (done_q == '0)) begin
          grant_idx_d = arb_idx;
          grant_oh_d  = arb_gnt;
          dvnd_d      = dvnd_flat[int'(arb_idx)*W +: W];
          dvsr_d      = dvsr_flat[int'(arb_idx)*W +: W];
          state_d     = LOAD;
        end
      end
      LOAD: begin
`ifdef DIV_ZERO_BYPASS_EN
        if (dvsr_q == '0) state_d = CAPTURE;
        else
`endif
        if (div_ready) begin
          start_d = 1'b1;
          stall_d = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!div_ready) begin
          state_d = WAIT_DONE;
        end else if (stall_q == 2'(STALL_LIMIT - 1)) begin
          // Divider never went busy: it finished within the start cycle.
          state_d = CAPTURE;
        end else begin
          stall_d = stall_q + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (div_ready) state_d = CAPTURE;
      end
      CAPTURE: begin
        done_d  = grant_oh_q;
        quo_d   = div_quo;
        rem_d   = div_rem;
        ptr_d   = (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);
        state_d = IDLE;
`ifdef DIV_ZERO_BYPASS_EN
        if (dvsr_q == '0) begin
          quo_d  = ones32[W-1:0];
          rem_d  = dvnd_q;
          div0_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
      done_q      <= '0;
      dvnd_q      <= '0;
      dvsr_q      <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      start_q     <= 1'b0;
      stall_q     <= '0;
`ifdef DIV_ZERO_BYPASS_EN
      div0_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_oh_q  <= grant_oh_d;
      done_q      <= done_d;
      dvnd_q      <= dvnd_d;
      dvsr_q      <= dvsr_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      start_q     <= start_d;
      stall_q     <= stall_d;
`ifdef DIV_ZERO_BYPASS_EN
      div0_q      <= div0_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant_idx = grant_idx_q;
  assign done      = done_q;
  assign quo_out   = quo_q;
  assign rem_out   = rem_q;
  assign div_start = start_q;
  assign div_dvnd  = dvnd_q;
  assign div_dvsr  = dvsr_q;
`ifdef DIV_ZERO_BYPASS_EN
  assign div0_err  = div0_q;
`endif

endmodule
